// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one I2C_Driver among NUM_CH controllers.
// Define ARB_TIMEOUT_EN to bound bus ownership to TIMEOUT_CYCLES.
module i2c_bus_arbiter #(
  parameter int NUM_CH         = 3,
  parameter int DW             = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    ch_req,
  input  logic [NUM_CH-1:0]    ch_ena,
  input  logic [NUM_CH-1:0]    ch_rw,
  input  logic [NUM_CH-1:0]    ch_start_transfer,
  input  logic [NUM_CH-1:0]    ch_stop_transfer,
  input  logic [NUM_CH-1:0]    ch_r_start,
  input  logic [NUM_CH*DW-1:0] ch_data_wr,
  output logic [DW-1:0]        ch_data_rd,
  output logic [NUM_CH-1:0]    ch_busy,
  output logic [NUM_CH-1:0]    ch_ready,
  output logic [NUM_CH-1:0]    ch_ack_err,
  output logic [NUM_CH-1:0]    ch_grant,
  output logic                 drv_ena,
  output logic                 drv_rw,
  output logic                 drv_start_transfer,
  output logic                 drv_stop_transfer,
  output logic                 drv_r_start,
  output logic [DW-1:0]        drv_data_wr,
  input  logic [DW-1:0]        drv_data_rd,
  input  logic                 drv_busy,
  input  logic                 drv_ready,
  input  logic                 drv_ack_err,
  output logic                 timeout
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_OWN,
    S_DRAIN,
    S_REL
  } state_t;

  state_t              state, state_d;
  logic [IW-1:0]       g;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       pick;
  logic                found;
  logic [NUM_CH-1:0]   grant_q;
  logic [NUM_CH-1:0]   elig;
  int                  idx;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0]     cnt;
  logic              to_fire;
  logic              to_q;
  logic [NUM_CH-1:0] mask;

  // A timed-out channel sits out arbitration until it lowers its request.
  assign to_fire = (state == S_OWN || state == S_DRAIN) &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign elig    = ch_req & ~mask;
  assign timeout = to_q;

  // Ownership watchdog, sticky flag and per-channel re-arbitration mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      to_q <= 1'b0;
      mask <= '0;
    end else begin
      if (state == S_IDLE)
        cnt <= '0;
      else if (state == S_OWN || state == S_DRAIN)
        cnt <= cnt + 1'b1;
      to_q <= to_q | to_fire;
      mask <= (mask & ch_req) | (to_fire ? grant_q : '0);
    end
  end
`else
  assign elig    = ch_req;
  assign timeout = 1'b0;
`endif

  // First eligible requester at or after the round-robin pointer.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // Next-state logic for the ownership sequence.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (found) state_d = S_GRANT;
      S_GRANT: state_d = ch_req[g] ? S_OWN : S_REL;
      S_OWN:   if (!ch_req[g]) state_d = S_DRAIN;
      S_DRAIN: if (!drv_busy) state_d = S_REL;
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    if (to_fire) state_d = S_REL;
`endif
  end

  // State, owner index, grant vector and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      g       <= '0;
      ptr     <= '0;
      grant_q <= '0;
    end else begin
      state <= state_d;
      if (state == S_IDLE && found) begin
        g       <= pick;
        grant_q <= {{(NUM_CH-1){1'b0}}, 1'b1} << pick;
      end
      if (state_d == S_REL && state != S_REL)
        grant_q <= '0;
      if (state == S_REL)
        ptr <= (g == IW'(NUM_CH - 1)) ? '0 : g + 1'b1;
    end
  end

  assign ch_grant   = grant_q;
  assign ch_data_rd = drv_data_rd;

  // Driver mux from the registered owner; non-owners see a busy driver.
  always_comb begin
    drv_ena            = 1'b0;
    drv_rw             = 1'b0;
    drv_start_transfer = 1'b0;
    drv_stop_transfer  = 1'b0;
    drv_r_start        = 1'b0;
    drv_data_wr        = '0;
    ch_busy            = '1;
    ch_ready           = '0;
    ch_ack_err         = '0;
    case (state)
      S_GRANT: begin
        ch_busy[g]  = drv_busy;
        ch_ready[g] = drv_ready;
      end
      S_OWN, S_DRAIN: begin
        drv_ena            = (state == S_OWN) ? ch_ena[g] : 1'b0;
        drv_rw             = ch_rw[g];
        drv_start_transfer = ch_start_transfer[g];
        drv_stop_transfer  = ch_stop_transfer[g];
        drv_r_start        = ch_r_start[g];
        drv_data_wr        = ch_data_wr[int'(g)*DW +: DW];
        ch_busy[g]         = drv_busy;
        ch_ready[g]        = drv_ready;
        ch_ack_err[g]      = drv_ack_err;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: directed bench for i2c_bus_arbiter, NUM_CH=3.
// Grant order is checked by a queue-driven monitor.
module tb_i2c_bus_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    ch_req, ch_ena, ch_rw, ch_start_transfer;
  logic [N-1:0]    ch_stop_transfer, ch_r_start;
  logic [N*DW-1:0] ch_data_wr;
  logic [DW-1:0]   ch_data_rd;
  logic [N-1:0]    ch_busy, ch_ready, ch_ack_err, ch_grant;
  logic            drv_ena, drv_rw, drv_start_transfer;
  logic            drv_stop_transfer, drv_r_start;
  logic [DW-1:0]   drv_data_wr, drv_data_rd;
  logic            drv_busy, drv_ready, drv_ack_err;
  logic            timeout;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  i2c_bus_arbiter #(
    .NUM_CH(N), .DW(DW), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req(ch_req), .ch_ena(ch_ena), .ch_rw(ch_rw),
    .ch_start_transfer(ch_start_transfer),
    .ch_stop_transfer(ch_stop_transfer),
    .ch_r_start(ch_r_start), .ch_data_wr(ch_data_wr),
    .ch_data_rd(ch_data_rd), .ch_busy(ch_busy),
    .ch_ready(ch_ready), .ch_ack_err(ch_ack_err),
    .ch_grant(ch_grant), .drv_ena(drv_ena), .drv_rw(drv_rw),
    .drv_start_transfer(drv_start_transfer),
    .drv_stop_transfer(drv_stop_transfer),
    .drv_r_start(drv_r_start), .drv_data_wr(drv_data_wr),
    .drv_data_rd(drv_data_rd), .drv_busy(drv_busy),
    .drv_ready(drv_ready), .drv_ack_err(drv_ack_err),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ch_grant != '0) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s no grant within 40 cycles", name);
  endtask

  task automatic wait_release(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ch_grant == '0) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s grant still 0x%0h", name, ch_grant);
  endtask

  // Monitor: each new grant is popped against the queue; gap and one-hot.
  initial begin
    logic [N-1:0] prev;
    logic [N-1:0] eg;
    int           zeros;
    int           e;
    prev  = '0;
    zeros = 99;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        zeros = 99;
      end else begin
        if (ch_grant != '0 && prev == '0) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL grant_unexpected actual=%b", ch_grant);
          end else begin
            e  = exp_q.pop_front();
            eg = N'(1 << e);
            check("grant_order", 32'(ch_grant), 32'(eg));
          end
          check("grant_gap_ok", 32'(zeros >= 2), 32'd1);
        end
        if (ch_grant == '0) zeros++;
        else zeros = 0;
        check("grant_onehot", 32'($countones(ch_grant) <= 1), 32'd1);
      end
      prev = rst_n ? ch_grant : '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    int cnt;
    rst_n             = 1'b0;
    ch_req            = '0;
    ch_ena            = 3'b111;
    ch_rw             = 3'b101;
    ch_start_transfer = 3'b111;
    ch_stop_transfer  = 3'b111;
    ch_r_start        = 3'b111;
    ch_data_wr        = 24'h33A511;
    drv_data_rd       = 8'h3C;
    drv_busy          = 1'b0;
    drv_ready         = 1'b1;
    drv_ack_err       = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_grant", 32'(ch_grant), 32'h0);
    check("rst_busy", 32'(ch_busy), 32'h7);
    check("rst_ready", 32'(ch_ready), 32'h0);
    check("rst_ack_err", 32'(ch_ack_err), 32'h0);
    check("rst_drv_ena", 32'(drv_ena), 32'h0);
    check("rst_drv_data", 32'(drv_data_wr), 32'h0);
    check("rst_drv_start", 32'(drv_start_transfer), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("data_rd_bcast", 32'(ch_data_rd), 32'h3C);
    drv_ack_err = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_drv_ena", 32'(drv_ena), 32'h0);
    check("idle_busy", 32'(ch_busy), 32'h7);

    // Single requester: GRANT keeps driver quiet, OWN passes through.
    tick();
    exp_q.push_back(0);
    ch_req = 3'b001;
    wait_grant("single");
    check("grant_drv_quiet", 32'(drv_ena), 32'h0);
    check("grant_busy", 32'(ch_busy), 32'h6);
    check("grant_ready", 32'(ch_ready), 32'h1);
    @(negedge clk);
    check("own_drv_ena", 32'(drv_ena), 32'h1);
    check("own_drv_rw", 32'(drv_rw), 32'h1);
    check("own_busy_others", 32'(ch_busy[2:1]), 32'h3);
    check("own_drv_data", 32'(drv_data_wr), 32'h11);
    tick();
    ch_ena = 3'b110;
    @(negedge clk);
    check("own_ena_follow", 32'(drv_ena), 32'h0);
    tick();
    ch_req = '0;
    ch_ena = 3'b111;
    wait_release("single");

    // Round robin from a fresh pointer; channel 0 re-raises and queues.
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(0);
    ch_req = 3'b111;
    for (int s = 0; s < 4; s++) begin
      int e;
      e = (s == 3) ? 0 : s;
      wait_grant("rr");
      @(negedge clk);
      repeat (2) tick();
      ch_req[e] = 1'b0;
      wait_release("rr");
      if (s == 0) begin
        tick();
        ch_req[0] = 1'b1;
      end
    end

    // Channel 1 owns: data mux, ack_err steering, read broadcast.
    tick();
    drv_data_rd = 8'h5C;
    exp_q.push_back(1);
    ch_req = 3'b010;
    wait_grant("ch1");
    @(negedge clk);
    tick();
    drv_ack_err = 1'b1;
    @(negedge clk);
    check("ch1_drv_data", 32'(drv_data_wr), 32'hA5);
    check("ch1_ack_err", 32'(ch_ack_err), 32'h2);
    check("ch1_ready", 32'(ch_ready), 32'h2);
    check("ch1_data_rd", 32'(ch_data_rd), 32'h5C);
    tick();
    drv_ack_err = 1'b0;
    @(negedge clk);
    check("ch1_ack_clear", 32'(ch_ack_err), 32'h0);

    // Drop request while the driver is still busy for ~50 cycles.
    tick();
    drv_busy = 1'b1;
    exp_q.push_back(2);
    ch_req[2] = 1'b1;
    tick();
    ch_req[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      check("drain_ena_low", 32'(drv_ena), 32'h0);
      check("drain_grant_held", 32'(ch_grant), 32'h2);
    end
    check("drain_data_held", 32'(drv_data_wr), 32'hA5);
    tick();
    drv_busy = 1'b0;
    @(negedge clk);
    check("drain_last", 32'(ch_grant), 32'h2);
    @(negedge clk);
    check("drain_release", 32'(ch_grant), 32'h0);
    wait_grant("after_drain");

    // Asynchronous reset during channel 2 ownership.
    @(negedge clk);
    check("pre_rst_ena", 32'(drv_ena), 32'h1);
    check("pre_rst_data", 32'(drv_data_wr), 32'h33);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_drv_ena", 32'(drv_ena), 32'h0);
    check("arst_drv_data", 32'(drv_data_wr), 32'h0);
    check("arst_grant", 32'(ch_grant), 32'h0);
    check("arst_busy", 32'(ch_busy), 32'h7);
    tick();
    ch_req = 3'b111;
    exp_q.push_back(0);
    tick();
    rst_n = 1'b1;
    wait_grant("post_rst");
    tick();
    ch_req = '0;
    wait_release("post_rst");
    repeat (4) tick();

`ifdef ARB_TIMEOUT_EN
    // Channel 2 never lets go: forced release and masking.
    exp_q.push_back(2);
    ch_req = 3'b100;
    wait_grant("to_grant");
    cnt = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ch_grant == '0) break;
      cnt++;
    end
    check("to_hold_len", 32'(cnt >= 100 && cnt <= 102), 32'd1);
    check("to_flag", 32'(timeout), 32'h1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("to_masked", 32'(ch_grant), 32'h0);
    end
    tick();
    ch_req[2] = 1'b0;
    tick();
    exp_q.push_back(2);
    ch_req[2] = 1'b1;
    wait_grant("to_regrant");
    check("to_sticky", 32'(timeout), 32'h1);
    tick();
    ch_req = '0;
    wait_release("to_regrant");
`else
    ch_req = 3'b100;
    exp_q.push_back(2);
    wait_grant("no_to");
    repeat (150) tick();
    @(negedge clk);
    check("no_to_held", 32'(ch_grant), 32'h4);
    check("timeout_tied", 32'(timeout), 32'h0);
    tick();
    ch_req = '0;
    wait_release("no_to");
`endif

    repeat (5) tick();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
